// File: rtl/occupancy_defs.sv
// Shared encodings for the gate sequence FSMs: 3-bit state codes and
// sensor patterns, where a pattern is the synchronised pair {a,b}.
package occupancy_defs;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EN0  = 3'd1;
    localparam logic [2:0] ST_EN1  = 3'd2;
    localparam logic [2:0] ST_EN2  = 3'd3;
    localparam logic [2:0] ST_EX0  = 3'd4;
    localparam logic [2:0] ST_EX1  = 3'd5;
    localparam logic [2:0] ST_EX2  = 3'd6;
    localparam logic [2:0] ST_INV  = 3'd7;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        EN0  = ST_EN0,
        EN1  = ST_EN1,
        EN2  = ST_EN2,
        EX0  = ST_EX0,
        EX1  = ST_EX1,
        EX2  = ST_EX2,
        INV  = ST_INV
    } gate_state_t;

    localparam logic [1:0] PAT_00 = 2'b00;
    localparam logic [1:0] PAT_01 = 2'b01;
    localparam logic [1:0] PAT_10 = 2'b10;
    localparam logic [1:0] PAT_11 = 2'b11;

endpackage

// File: rtl/gate_fsm.sv
// One two-sensor gate: synchronises a/b, tracks the entry/exit sequence and
// emits registered one-cycle entry, exit and illegal-sequence pulses.
module gate_fsm
    import occupancy_defs::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic entry_pulse,
    output logic exit_pulse,
    output logic seq_err
);

    logic [SYNC_STAGES-1:0] a_sync_reg;
    logic [SYNC_STAGES-1:0] b_sync_reg;
    logic [1:0]             pat;
    gate_state_t            state_reg, state_next;
    logic                   entry_reg, entry_next;
    logic                   exit_reg, exit_next;
    logic                   err_reg, err_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_sync_reg <= '0;
            b_sync_reg <= '0;
        end else begin
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sync_reg[i] <= a_sync_reg[i-1];
                b_sync_reg[i] <= b_sync_reg[i-1];
            end
            a_sync_reg[0] <= a;
            b_sync_reg[0] <= b;
        end
    end

    assign pat = {a_sync_reg[SYNC_STAGES-1], b_sync_reg[SYNC_STAGES-1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            entry_reg <= 1'b0;
            exit_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            entry_reg <= entry_next;
            exit_reg  <= exit_next;
            err_reg   <= err_next;
        end
    end

    // Each step holds on its own pattern, steps back on the previous one,
    // and aborts with an error on anything else.
    always_comb begin
        state_next = state_reg;
        entry_next = 1'b0;
        exit_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: case (pat)
                PAT_10:  state_next = EN0;
                PAT_01:  state_next = EX0;
                PAT_11:  begin state_next = INV; err_next = 1'b1; end
                default: state_next = IDLE;
            endcase
            EN0: case (pat)
                PAT_10:  state_next = EN0;
                PAT_11:  state_next = EN1;
                PAT_00:  state_next = IDLE;
                default: begin state_next = IDLE; err_next = 1'b1; end
            endcase
            EN1: case (pat)
                PAT_11:  state_next = EN1;
                PAT_10:  state_next = EN0;
                PAT_01:  state_next = EN2;
                default: begin state_next = IDLE; err_next = 1'b1; end
            endcase
            EN2: case (pat)
                PAT_01:  state_next = EN2;
                PAT_11:  state_next = EN1;
                PAT_00:  begin state_next = IDLE; entry_next = 1'b1; end
                default: begin state_next = IDLE; err_next = 1'b1; end
            endcase
            EX0: case (pat)
                PAT_01:  state_next = EX0;
                PAT_11:  state_next = EX1;
                PAT_00:  state_next = IDLE;
                default: begin state_next = IDLE; err_next = 1'b1; end
            endcase
            EX1: case (pat)
                PAT_11:  state_next = EX1;
                PAT_01:  state_next = EX0;
                PAT_10:  state_next = EX2;
                default: begin state_next = IDLE; err_next = 1'b1; end
            endcase
            EX2: case (pat)
                PAT_10:  state_next = EX2;
                PAT_11:  state_next = EX1;
                PAT_00:  begin state_next = IDLE; exit_next = 1'b1; end
                default: begin state_next = IDLE; err_next = 1'b1; end
            endcase
            INV: begin
                if (pat == PAT_00) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign entry_pulse = entry_reg;
    assign exit_pulse  = exit_reg;
    assign seq_err     = err_reg;

endmodule

// File: rtl/multi_gate_occupancy_counter.sv
// Car-park occupancy counter fed by NUM_GATES independent gates; nets all
// gate events per cycle, clamps to [0, CAPACITY] and supports a preset load.
module multi_gate_occupancy_counter
    import occupancy_defs::*;
#(
    parameter int NUM_GATES   = 2,
    parameter int CAPACITY    = 15,
    parameter int CNT_W       = $clog2(CAPACITY + 1),
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] a,
    input  logic [NUM_GATES-1:0] b,
    input  logic                 load,
    input  logic [CNT_W-1:0]     load_val,
    output logic [CNT_W-1:0]     occupancy,
    output logic                 full,
    output logic                 empty,
    output logic [NUM_GATES-1:0] entry_pulse,
    output logic [NUM_GATES-1:0] exit_pulse,
    output logic [NUM_GATES-1:0] seq_err,
    output logic                 cnt_err
);

    localparam logic [CNT_W-1:0]        CAP_VAL = CNT_W'(CAPACITY);
    localparam logic signed [CNT_W+3:0] CAP_S   = (CNT_W+4)'(CAPACITY);

    logic [CNT_W-1:0]        occupancy_reg, occupancy_next;
    logic                    cnt_err_reg, cnt_err_next;
    logic [3:0]              n_in, n_out;
    logic signed [CNT_W+3:0] occ_ext, in_ext, out_ext, sum;

    generate
        for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_gate
            gate_fsm #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_gate (
                .clk         (clk),
                .reset       (reset),
                .a           (a[gi]),
                .b           (b[gi]),
                .entry_pulse (entry_pulse[gi]),
                .exit_pulse  (exit_pulse[gi]),
                .seq_err     (seq_err[gi])
            );
        end
    endgenerate

    always_comb begin
        n_in  = '0;
        n_out = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            n_in  = n_in + 4'(entry_pulse[i]);
            n_out = n_out + 4'(exit_pulse[i]);
        end
    end

    // Four guard bits keep the net sum exact for up to 8 gates either way.
    always_comb begin
        occ_ext = {4'b0000, occupancy_reg};
        in_ext  = (CNT_W+4)'(n_in);
        out_ext = (CNT_W+4)'(n_out);
        sum     = occ_ext + in_ext - out_ext;

        occupancy_next = sum[CNT_W-1:0];
        cnt_err_next   = cnt_err_reg;
        if (load) begin
            occupancy_next = (load_val > CAP_VAL) ? CAP_VAL : load_val;
            cnt_err_next   = 1'b0;
        end else if (sum < 0) begin
            occupancy_next = '0;
            cnt_err_next   = 1'b1;
        end else if (sum > CAP_S) begin
            occupancy_next = CAP_VAL;
            cnt_err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occupancy_reg <= '0;
            cnt_err_reg   <= 1'b0;
        end else begin
            occupancy_reg <= occupancy_next;
            cnt_err_reg   <= cnt_err_next;
        end
    end

    assign occupancy = occupancy_reg;
    assign cnt_err   = cnt_err_reg;
    assign full      = (occupancy_reg == CAP_VAL);
    assign empty     = (occupancy_reg == '0);

endmodule

// File: tb/tb_multi_gate_occupancy_counter.sv
// Directed bench: a default counter (CAPACITY 15) and a CAPACITY=3 instance,
// gate sequences driven by hand with hand-computed expected counts.
module tb_multi_gate_occupancy_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] a, b;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] occupancy;
    logic       full, empty, cnt_err;
    logic [1:0] entry_pulse, exit_pulse, seq_err;

    logic [1:0] a_c, b_c;
    logic       load_c;
    logic [1:0] load_val_c;
    logic [1:0] occupancy_c;
    logic       full_c, empty_c, cnt_err_c;
    logic [1:0] entry_pulse_c, exit_pulse_c, seq_err_c;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int ent_cnt [2] = '{0, 0};
    int ext_cnt [2] = '{0, 0};
    int err_cnt [2] = '{0, 0};
    int ent_c_cnt   = 0;
    int ent_cyc0    = -1;
    int ext_cyc1    = -2;
    int e0, x1, s0, s1;

    always #5 clk = ~clk;

    multi_gate_occupancy_counter dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .load(load), .load_val(load_val),
        .occupancy(occupancy), .full(full), .empty(empty),
        .entry_pulse(entry_pulse), .exit_pulse(exit_pulse), .seq_err(seq_err),
        .cnt_err(cnt_err)
    );

    multi_gate_occupancy_counter #(.NUM_GATES(2), .CAPACITY(3)) dut_cap (
        .clk(clk), .reset(reset), .a(a_c), .b(b_c), .load(load_c), .load_val(load_val_c),
        .occupancy(occupancy_c), .full(full_c), .empty(empty_c),
        .entry_pulse(entry_pulse_c), .exit_pulse(exit_pulse_c), .seq_err(seq_err_c),
        .cnt_err(cnt_err_c)
    );

    // Pulse monitor, sampled mid-cycle; each high sample is one pulse cycle.
    always @(negedge clk) begin
        cycle = cycle + 1;
        for (int i = 0; i < 2; i++) begin
            ent_cnt[i] = ent_cnt[i] + int'(entry_pulse[i]);
            ext_cnt[i] = ext_cnt[i] + int'(exit_pulse[i]);
            err_cnt[i] = err_cnt[i] + int'(seq_err[i]);
        end
        ent_c_cnt = ent_c_cnt + int'(entry_pulse_c[0]);
        if (entry_pulse[0]) ent_cyc0 = cycle;
        if (exit_pulse[1])  ext_cyc1 = cycle;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("check %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pat(input bit cap, input int g, input logic [1:0] pat);
        if (cap) begin
            a_c[g] = pat[1];
            b_c[g] = pat[0];
        end else begin
            a[g] = pat[1];
            b[g] = pat[0];
        end
    endtask

    task automatic run_seq(input bit cap, input int g,
                           input logic [1:0] p0, input logic [1:0] p1,
                           input logic [1:0] p2, input logic [1:0] p3);
        set_pat(cap, g, p0); ticks(3);
        set_pat(cap, g, p1); ticks(3);
        set_pat(cap, g, p2); ticks(3);
        set_pat(cap, g, p3); ticks(3);
        ticks(5);
        $display("seq dut%0d gate%0d %b %b %b %b", cap, g, p0, p1, p2, p3);
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1; load_val = v; ticks(1);
        load = 1'b0; load_val = '0;
        $display("load %0d", v);
    endtask

    initial begin
        reset = 1'b0; a = '0; b = '0; load = 1'b0; load_val = '0;
        a_c = '0; b_c = '0; load_c = 1'b0; load_val_c = '0;
        ticks(3);
        check_eq("rst_occ", 32'(occupancy), 0);
        check_eq("rst_empty", 32'(empty), 1);
        check_eq("rst_full", 32'(full), 0);
        check_eq("rst_cnt_err", 32'(cnt_err), 0);
        check_eq("rst_pulses", 32'({entry_pulse, exit_pulse, seq_err}), 0);
        check_eq("rst_occ_cap", 32'(occupancy_c), 0);
        reset = 1'b1;
        ticks(2);

        // Single entry on gate0
        e0 = ent_cnt[0]; s0 = err_cnt[0];
        run_seq(1'b0, 0, 2'b10, 2'b11, 2'b01, 2'b00);
        check_eq("entry_pulse_cycles", 32'(ent_cnt[0] - e0), 1);
        check_eq("entry_no_seq_err", 32'(err_cnt[0] - s0), 0);
        check_eq("entry_occ", 32'(occupancy), 1);
        check_eq("entry_empty", 32'(empty), 0);

        // Back-out: no count
        e0 = ent_cnt[0]; s0 = err_cnt[0];
        run_seq(1'b0, 0, 2'b10, 2'b11, 2'b10, 2'b00);
        check_eq("backout_no_pulse", 32'(ent_cnt[0] - e0), 0);
        check_eq("backout_no_err", 32'(err_cnt[0] - s0), 0);
        check_eq("backout_occ", 32'(occupancy), 1);

        // Gate1 both sensors from IDLE: single error, INV held until 00
        s1 = err_cnt[1];
        set_pat(1'b0, 1, 2'b11); ticks(3);
        ticks(8);
        check_eq("inv_err_once", 32'(err_cnt[1] - s1), 1);
        set_pat(1'b0, 1, 2'b00); ticks(6);
        check_eq("inv_err_after_00", 32'(err_cnt[1] - s1), 1);
        check_eq("inv_occ", 32'(occupancy), 1);
        x1 = ext_cnt[1];
        run_seq(1'b0, 1, 2'b01, 2'b11, 2'b10, 2'b00);
        check_eq("exit_after_inv", 32'(ext_cnt[1] - x1), 1);
        check_eq("exit_occ", 32'(occupancy), 0);
        check_eq("exit_empty", 32'(empty), 1);

        // Simultaneous entry (gate0) and exit (gate1) from 5
        do_load(4'd5);
        check_eq("load5_occ", 32'(occupancy), 5);
        e0 = ent_cnt[0]; x1 = ext_cnt[1];
        a = 2'b01; b = 2'b10; ticks(3);
        a = 2'b11; b = 2'b11; ticks(3);
        a = 2'b10; b = 2'b01; ticks(3);
        a = 2'b00; b = 2'b00; ticks(8);
        $display("seq dut0 simultaneous entry g0 exit g1");
        check_eq("simul_entry", 32'(ent_cnt[0] - e0), 1);
        check_eq("simul_exit", 32'(ext_cnt[1] - x1), 1);
        check_eq("simul_same_cycle", 32'(ent_cyc0), 32'(ext_cyc1));
        check_eq("simul_occ", 32'(occupancy), 5);

        // Underflow clamp, then load clears the flag
        do_load(4'd0);
        run_seq(1'b0, 1, 2'b01, 2'b11, 2'b10, 2'b00);
        check_eq("under_occ", 32'(occupancy), 0);
        check_eq("under_cnt_err", 32'(cnt_err), 1);
        do_load(4'd0);
        check_eq("under_load_clr", 32'(cnt_err), 0);

        // Reset while gate0 sits in EN2
        do_load(4'd5);
        e0 = ent_cnt[0];
        set_pat(1'b0, 0, 2'b10); ticks(3);
        set_pat(1'b0, 0, 2'b11); ticks(3);
        set_pat(1'b0, 0, 2'b01); ticks(5);
        reset = 1'b0; ticks(2);
        set_pat(1'b0, 0, 2'b00); reset = 1'b1; ticks(8);
        $display("reset mid-sequence");
        check_eq("midrst_no_pulse", 32'(ent_cnt[0] - e0), 0);
        check_eq("midrst_occ", 32'(occupancy), 0);
        check_eq("midrst_empty", 32'(empty), 1);

        // CAPACITY=3: four entries saturate
        for (int k = 1; k <= 4; k++) begin
            run_seq(1'b1, 0, 2'b10, 2'b11, 2'b01, 2'b00);
            if (k == 3) begin
                check_eq("cap3_occ", 32'(occupancy_c), 3);
                check_eq("cap3_full", 32'(full_c), 1);
                check_eq("cap3_cnt_err", 32'(cnt_err_c), 0);
            end
        end
        check_eq("cap4_pulses", 32'(ent_c_cnt), 4);
        check_eq("cap4_occ", 32'(occupancy_c), 3);
        check_eq("cap4_full", 32'(full_c), 1);
        check_eq("cap4_cnt_err", 32'(cnt_err_c), 1);
        load_c = 1'b1; load_val_c = 2'd1; ticks(1);
        load_c = 1'b0; load_val_c = '0;
        $display("load cap dut 1");
        check_eq("cap_load_occ", 32'(occupancy_c), 1);
        check_eq("cap_load_cnt_err", 32'(cnt_err_c), 0);
        check_eq("cap_load_full", 32'(full_c), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
